// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: operation encodings and default latencies.
// Used by mdu_unit and by the decode controller that produces MDUOpD.
package mdu_defs;

    localparam int unsigned MDU_OP_W = 4;

    // Default busy latencies (cycles Busy stays high per operation)
    localparam int unsigned MULT_CYCLES_DFLT = 5;
    localparam int unsigned DIV_CYCLES_DFLT  = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

endpackage

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit. Owns architectural HI/LO and models
// multi-cycle latency with a Busy flag. The result is computed when the
// operation launches and held in res_hi/res_lo until the counter expires.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   Start, MDUOp       launch pulse and operation code (mdu_defs encodings)
//   A, B               forwarded rs / rt operands
//   HIWrite, LOWrite   mthi / mtlo (HI/LO <= A), honoured only when idle
//   HIRead, LORead     mfhi / mflo select for MDUOut (HI has priority)
//   Busy               registered, high while an operation is in flight
//   HI, LO             architectural registers
//   MDUOut             combinational read port of HI/LO
module mdu_unit
    import mdu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DFLT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Start,
    input  logic [MDU_OP_W-1:0] MDUOp,
    input  logic [31:0]         A,
    input  logic [31:0]         B,
    input  logic                HIWrite,
    input  logic                LOWrite,
    input  logic                HIRead,
    input  logic                LORead,
    output logic                Busy,
    output logic [31:0]         HI,
    output logic [31:0]         LO,
    output logic [31:0]         MDUOut
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               divz;

    // Launch-time arithmetic
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               b_zero;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        dvsr_s;
    logic [31:0]        dvsr_u;
    logic [31:0]        uq_s;
    logic [31:0]        ur_s;
    logic [31:0]        q_s;
    logic [31:0]        r_s;
    logic [31:0]        q_u;
    logic [31:0]        r_u;
    logic               op_ok;
    logic [31:0]        nxt_hi;
    logic [31:0]        nxt_lo;
    logic [CNT_W-1:0]   nxt_cnt;

    // Result of the requested operation from the current operands
    always_comb begin
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'd0, A} * {32'd0, B};
        b_zero  = (B == 32'd0);

        // Signed divide on magnitudes; a zero divisor is replaced by 1 so the
        // divider never sees zero (the result is discarded via divz anyway).
        abs_a   = A[31] ? (~A + 32'd1) : A;
        abs_b   = B[31] ? (~B + 32'd1) : B;
        dvsr_s  = b_zero ? 32'd1 : abs_b;
        uq_s    = abs_a / dvsr_s;
        ur_s    = abs_a % dvsr_s;
        // Truncate toward zero; remainder follows dividend sign.
        // 0x80000000 / -1 wraps naturally to 0x80000000 rem 0.
        q_s     = (A[31] ^ B[31]) ? (~uq_s + 32'd1) : uq_s;
        r_s     = A[31] ? (~ur_s + 32'd1) : ur_s;

        dvsr_u  = b_zero ? 32'd1 : B;
        q_u     = A / dvsr_u;
        r_u     = A % dvsr_u;

        op_ok   = 1'b0;
        nxt_hi  = 32'd0;
        nxt_lo  = 32'd0;
        nxt_cnt = '0;
        case (MDUOp)
            MDU_MULT: begin
                op_ok   = 1'b1;
                nxt_hi  = prod_s[63:32];
                nxt_lo  = prod_s[31:0];
                nxt_cnt = CNT_W'(MULT_CYCLES);
            end
            MDU_MULTU: begin
                op_ok   = 1'b1;
                nxt_hi  = prod_u[63:32];
                nxt_lo  = prod_u[31:0];
                nxt_cnt = CNT_W'(MULT_CYCLES);
            end
            MDU_DIV: begin
                op_ok   = 1'b1;
                nxt_hi  = r_s;
                nxt_lo  = q_s;
                nxt_cnt = CNT_W'(DIV_CYCLES);
            end
            MDU_DIVU: begin
                op_ok   = 1'b1;
                nxt_hi  = r_u;
                nxt_lo  = q_u;
                nxt_cnt = CNT_W'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // Sequencer: IDLE accepts launches and mthi/mtlo; RUN counts down and commits
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            divz   <= 1'b0;
            Busy   <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (op_ok) begin
                            res_hi <= nxt_hi;
                            res_lo <= nxt_lo;
                            divz   <= b_zero && (MDUOp == MDU_DIV || MDUOp == MDU_DIVU);
                            cnt    <= nxt_cnt;
                            Busy   <= 1'b1;
                            state  <= S_RUN;
                        end
                    end else begin
                        if (HIWrite) HI <= A;
                        if (LOWrite) LO <= A;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                        if (!divz) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Read port reflects committed registers only (no mthi/mtlo bypass)
    always_comb begin
        if (HIRead)      MDUOut = HI;
        else if (LORead) MDUOut = LO;
        else             MDUOut = 32'd0;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: each launched operation pushes its
// expected {HI,LO}; a monitor pops and compares whenever Busy falls.
module tb_mdu_unit;
    import mdu_defs::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HIWrite;
    logic        LOWrite;
    logic        HIRead;
    logic        LORead;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    int n_cmp;
    int n_bad;
    logic [63:0] exp_q[$];
    logic        busy_prev;

    mdu_unit dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDUOp   (MDUOp),
        .A       (A),
        .B       (B),
        .HIWrite (HIWrite),
        .LOWrite (LOWrite),
        .HIRead  (HIRead),
        .LORead  (LORead),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO),
        .MDUOut  (MDUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every Busy fall is a commit point (or a reset abort)
    initial busy_prev = 1'b0;
    always @(negedge clk) begin
        if (busy_prev && !Busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit", {HI, LO}, 64'hxxxx_xxxx_xxxx_xxxx);
            end else begin
                check("commit_hilo", {HI, LO}, exp_q.pop_front());
            end
        end
        busy_prev = Busy;
    end

    // Launch an op, count Busy cycles, verify HI/LO hold while busy.
    // inject=1 also drives an mthi and a new Start mid-flight.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input logic [63:0] exp_hl,
                          input bit inject);
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        int n;
        hold_hi = HI;
        hold_lo = LO;
        exp_q.push_back(exp_hl);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        tick();
        Start = 1'b0; MDUOp = MDU_NONE;
        n = 0;
        while (Busy && n < 30) begin
            n++;
            check({name, "_hold"}, {HI, LO}, {hold_hi, hold_lo});
            HIWrite = 1'b0; Start = 1'b0; MDUOp = MDU_NONE;
            if (inject && n == 2) begin
                HIWrite = 1'b1; A = 32'h1234_5678;
            end else if (inject && n == 4) begin
                Start = 1'b1; MDUOp = MDU_MULT; A = 32'd3; B = 32'd5;
            end
            tick();
        end
        HIWrite = 1'b0; Start = 1'b0; MDUOp = MDU_NONE;
        check({name, "_busy_cycles"}, 64'(n), 64'(exp_cyc));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b1; Start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
        HIWrite = 1'b0; LOWrite = 1'b0; HIRead = 1'b0; LORead = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_mduout", 64'(MDUOut), 64'd0);

        // Signed multiply: -3 * 7 = -21
        run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        LORead = 1'b1; #1;
        check("mflo", 64'(MDUOut), 64'h0000_0000_FFFF_FFEB);
        HIRead = 1'b1; #1;
        check("mfhi_prio", 64'(MDUOut), 64'h0000_0000_FFFF_FFFF);
        HIRead = 1'b0; LORead = 1'b0; #1;
        check("no_read", 64'(MDUOut), 64'd0);

        // Unsigned multiply, HI/LO hold checked each busy cycle
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 64'h0000_0001_FFFF_FFFE, 1'b0);

        // Signed divide: -7 / 2 = -3 rem -1
        run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);

        // Divide by zero: full latency, registers unchanged
        run_op("divz", MDU_DIVU, 32'd7, 32'd0, 10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);

        // 100 / 7 = 14 rem 2, with mthi and Start injected while busy
        run_op("div_inject", MDU_DIV, 32'd100, 32'd7, 10, 64'h0000_0002_0000_000E, 1'b1);
        tick();
        check("post_inject_idle", 64'(Busy), 64'd0);
        check("post_inject_hilo", {HI, LO}, 64'h0000_0002_0000_000E);

        // mthi / mtlo / both
        HIWrite = 1'b1; A = 32'h1234_5678; tick(); HIWrite = 1'b0;
        check("mthi", {HI, LO}, 64'h1234_5678_0000_000E);
        LOWrite = 1'b1; A = 32'hCAFE_F00D; tick(); LOWrite = 1'b0;
        check("mtlo", {HI, LO}, 64'h1234_5678_CAFE_F00D);
        HIWrite = 1'b1; LOWrite = 1'b1; A = 32'h0BAD_BEEF; tick();
        HIWrite = 1'b0; LOWrite = 1'b0;
        check("mthi_mtlo", {HI, LO}, 64'h0BAD_BEEF_0BAD_BEEF);

        // MDUOut does not bypass a pending mthi
        HIWrite = 1'b1; HIRead = 1'b1; A = 32'h5555_AAAA; #1;
        check("no_bypass", 64'(MDUOut), 64'h0000_0000_0BAD_BEEF);
        tick(); HIWrite = 1'b0; HIRead = 1'b0;
        check("mthi2", 64'(HI), 64'h0000_0000_5555_AAAA);

        // Start with a non-mult/div op is ignored, and blocks mthi
        Start = 1'b1; MDUOp = MDU_MTHI; HIWrite = 1'b1; A = 32'hDEAD_0000;
        tick();
        Start = 1'b0; MDUOp = MDU_NONE; HIWrite = 1'b0;
        check("bad_op_busy", 64'(Busy), 64'd0);
        check("bad_op_hi", 64'(HI), 64'h0000_0000_5555_AAAA);

        // Overflow corner and unsigned divide
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 1'b0);
        run_op("divu", MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 10, 64'h0000_000F_0FFF_FFFF, 1'b0);

        // Back-to-back multiplies, second launched in the first idle cycle
        run_op("b2b_1", MDU_MULT, 32'h0001_0000, 32'h0001_0000, 5, 64'h0000_0001_0000_0000, 1'b0);
        run_op("b2b_2", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'h0000_0000_0000_0001, 1'b0);

        // Reset in cycle 3 of a divide: abort to zero, no later commit
        Start = 1'b1; MDUOp = MDU_DIV; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0; MDUOp = MDU_NONE;
        tick(); tick();
        check("pre_reset_busy", 64'(Busy), 64'd1);
        exp_q.push_back(64'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("reset_mid_busy", 64'(Busy), 64'd0);
        check("reset_mid_hilo", {HI, LO}, 64'd0);
        repeat (12) tick();
        check("no_late_commit", {HI, LO}, 64'd0);

        tick(); tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
